// File: rtl/exp_arbiter_16.sv
// exp_arbiter_16: shares one exp_1_block_16 among NUM_REQ softmax lanes, routing results back by lane tag
// Ports: clock_i, reset_i (async, active-high); cfg_req_en_i lane enable mask latched when a batch starts;
//   req_data_i/req_valid_i/req_last_i lane samples, req_ready_o one-hot grant;
//   exp_data_o/exp_data_valid_o/exp_downscale_done_o drive the exp unit, exp_data_i/exp_data_valid_i return from it;
//   rsp_data_o shared result, rsp_valid_o/rsp_last_o one-hot per lane; all_done_o batch pulse; err_o sticky orphan result.
// Build option: EXP_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module exp_arbiter_16 #(
  parameter int DATA_SIZE = 16,
  parameter int NUM_REQ = 4,
  parameter int EXP_LATENCY = 1
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           cfg_req_en_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [DATA_SIZE-1:0]         exp_data_o,
  output logic                         exp_data_valid_o,
  output logic                         exp_downscale_done_o,
  input  logic [DATA_SIZE-1:0]         exp_data_i,
  input  logic                         exp_data_valid_i,
  output logic [DATA_SIZE-1:0]         rsp_data_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  output logic [NUM_REQ-1:0]           rsp_last_o,
  output logic                         all_done_o,
  output logic                         err_o
);
  localparam int IW = $clog2(NUM_REQ);
  // one extra slot covers the registered issue stage ahead of the exp unit
  localparam int TD = EXP_LATENCY + 1;
  localparam int CW = $clog2(TD + 1);
  localparam int TS = 1 << CW;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  logic [1:0] r_state;
  logic [NUM_REQ-1:0] r_en, r_fin, w_elig, w_gnt, w_fin_nxt;
  logic [IW-1:0] w_base, w_gidx, w_k;
  logic w_xfer, w_pop, w_last;
  logic [DATA_SIZE-1:0] w_data;
  logic [CW-1:0] r_cnt, w_wi;
  logic [IW-1:0] r_tg [TS];
  logic r_tl [TS];
`ifdef EXP_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IW-1:0] r_ptr;
  assign w_base = r_ptr;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) r_ptr <= '0;
    else if (w_xfer) r_ptr <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
`endif
  assign w_elig = (r_state == S_RUN) ? r_en & ~r_fin & req_valid_i : '0;
  // scanning downward lets the lane closest to w_base win
  always_comb begin
    w_xfer = 1'b0;
    w_gidx = '0;
    w_k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_k = IW'((int'(w_base) + i) % NUM_REQ);
      if (w_elig[w_k]) begin
        w_xfer = 1'b1;
        w_gidx = w_k;
      end
    end
  end
  assign w_gnt = NUM_REQ'(w_xfer) << w_gidx;
  assign req_ready_o = w_gnt;
  assign w_data = req_data_i[int'(w_gidx)*DATA_SIZE +: DATA_SIZE];
  assign w_last = req_last_i[w_gidx];
  assign w_fin_nxt = r_fin | (w_last ? w_gnt : '0);
  assign w_pop = exp_data_valid_i && r_cnt != '0;
  assign w_wi = r_cnt - CW'(w_pop);
  assign all_done_o = r_state == S_DONE;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      r_state <= S_IDLE;
      r_en <= '0;
      r_fin <= '0;
      exp_data_o <= '0;
      exp_data_valid_o <= 1'b0;
      exp_downscale_done_o <= 1'b0;
    end else begin
      exp_data_valid_o <= w_xfer;
      exp_downscale_done_o <= 1'b0;
      if (w_xfer) exp_data_o <= w_data;
      r_fin <= w_fin_nxt;
      case (r_state)
        S_IDLE: if (|(req_valid_i & cfg_req_en_i)) begin
          r_state <= S_RUN;
          r_en <= cfg_req_en_i;
        end
        S_RUN: if (w_fin_nxt == r_en) begin
          r_state <= S_DRAIN;
          exp_downscale_done_o <= 1'b1;
        end
        S_DRAIN: if (r_cnt == '0) r_state <= S_DONE;
        default: begin
          r_state <= S_IDLE;
          r_fin <= '0;
        end
      endcase
    end
  // tag FIFO: oldest at slot 0, shifted on every returned result
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      r_cnt <= '0;
      for (int i = 0; i < TS; i++) begin
        r_tg[i] <= '0;
        r_tl[i] <= 1'b0;
      end
      rsp_data_o <= '0;
      rsp_valid_o <= '0;
      rsp_last_o <= '0;
      err_o <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(w_xfer) - CW'(w_pop);
      if (w_pop)
        for (int i = 0; i < TS - 1; i++) begin
          r_tg[i] <= r_tg[i+1];
          r_tl[i] <= r_tl[i+1];
        end
      if (w_xfer) begin
        r_tg[w_wi] <= w_gidx;
        r_tl[w_wi] <= w_last;
      end
      rsp_valid_o <= NUM_REQ'(w_pop) << r_tg[0];
      rsp_last_o <= NUM_REQ'(w_pop & r_tl[0]) << r_tg[0];
      if (w_pop) rsp_data_o <= exp_data_i;
      if (exp_data_valid_i && r_cnt == '0) err_o <= 1'b1;
    end
endmodule
